main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multicycle main control unit for the MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath strobe and mux select, including the 2-bit `alu_op` consumed by the ALU control decoder. Memory accesses stall on a `mem_ready` handshake; undecodable opcodes raise a sticky error flag.

## Interface
- No parameters.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; forces state to S_RST.
- `opcode` in 6: instruction[31:26] from the instruction register, valid from DECODE onward.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `iord` out 1: address select, 0 = PC, 1 = ALUOut.
- `ir_write` out 1: instruction register load.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load if ALU zero (gated externally).
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = use funct field.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALUOut, 1 = memory data register.
- `reg_write` out 1: register file write.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `illegal_op` out 1: sticky; set on an unknown opcode in DECODE.
- `state` out 4: current state encoding, for debug.

## Operation
- States and encodings: S_RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Codes 13-15 are unused and recover to FETCH.
- Outputs are a pure function of `state`, except strobes explicitly qualified by `mem_ready`. Every output not listed for a state is 0.
- S_RST: all outputs 0. Next state is FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Dispatch on `opcode`:
  - 000000 (R-type) → EXECUTE
  - 100011 (lw) → MEMADR
  - 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - other → FETCH, and set illegal_op
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw; `opcode` is re-sampled here.
- MEMRD: mem_read=1, iord=1. Next state: MEMWB on mem_ready, else stay.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next state is FETCH.
- MEMWR: mem_write=1, iord=1, held until mem_ready. instr_done = mem_ready. Next state: FETCH on mem_ready, else stay.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1. Next state is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next state is FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Next state is FETCH.
- illegal_op is set on the DECODE cycle with an unknown opcode, visible from the next cycle. It is cleared only by reset. The FSM keeps executing after it is set.

## Timing
- Reset values, on the cycle after reset is sampled high: state=0, illegal_op=0, all other outputs 0. The first FETCH occurs one cycle after reset deasserts.
- Reset sampled high in any state, including mid-stall in MEMRD/MEMWR, goes to S_RST next cycle. No write strobe is asserted in S_RST.
- Latency in cycles with zero memory wait (mem_ready high on first request):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- instr_done pulses on the final cycle of each instruction. It never pulses for an illegal opcode.

## Test plan
- Reset then lw, mem_ready tied 1: state sequence is 0,1,2,3,4,5,1. instr_done is high only in state 5. reg_write=1 and mem_to_reg=1 in state 5.
- R-type with opcode=000000: alu_op=10 in EXECUTE. reg_dst=1 and reg_write=1 in ALUWB. Returns to FETCH after 4 cycles.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write stays high for 4 cycles. instr_done pulses once, coincident with mem_ready. Total latency is 7 cycles.
- beq then j: BRANCH drives alu_op=01, pc_src=01, branch=1. JUMP drives pc_src=10, pc_write=1. Both return to FETCH next cycle.
- FETCH with mem_ready low for 2 cycles: ir_write=0 and pc_write=0 while stalled. Both go to 1 on the mem_ready cycle, then DECODE follows.
- Opcode 111111 in DECODE: next state FETCH, illegal_op=1 and stays 1 through following instructions. Reset asserted mid-MEMRD stall: next state S_RST, illegal_op=0, all outputs 0.

Source files
------------

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back, driving every datapath strobe and mux select.
// Memory phases stall on mem_ready; unknown opcodes raise a sticky error flag.
module main_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_RST   = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      EXECUTE = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JUMP    = 4'd12
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;

   // State register and sticky illegal-opcode flag, cleared only by reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_RST;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic and Moore outputs (mem_ready-qualified strobes only).
   always_comb begin
      // NOTE: every output gets a default first so no case path infers a latch.
      state_d    = state_q;
      illegal_d  = illegal_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;

      case (state_q)
         S_RST: state_d = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:      state_d = EXECUTE;
               OP_LW, OP_SW:  state_d = MEMADR;
               OP_BEQ:        state_d = BRANCH;
               OP_ADDI:       state_d = ADDIEX;
               OP_J:          state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = FETCH;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         // Unused codes 13-15 recover to FETCH.
         default: state_d = FETCH;
      endcase
   end

   assign state      = state_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios with literal
// expectations, then randomized opcode/mem_ready/reset traffic compared every
// cycle against an instruction-script reference model.
module tb_main_control_fsm;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ILL  = 6'b111111;

   logic       clk, reset, mem_ready;
   logic [5:0] opcode;
   logic       mem_read, mem_write, iord, ir_write, pc_write, branch;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
   logic [3:0] state;
   logic [16:0] dut_vec;

   int checks = 0;
   int errors = 0;

   main_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .instr_done(instr_done),
      .illegal_op(illegal_op), .state(state)
   );

   assign dut_vec = {mem_read, mem_write, iord, ir_write, pc_write, branch,
                     pc_src, alu_src_a, alu_src_b, alu_op, reg_dst,
                     mem_to_reg, reg_write, instr_done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Output table: what each phase of an instruction drives.
   function automatic logic [16:0] exp_out(input int s, input logic mr);
      logic mrd, mwr, io, irw, pcw, br, sa, rd, m2r, rw, dn;
      logic [1:0] ps, sb, op;
      {mrd, mwr, io, irw, pcw, br, sa, rd, m2r, rw, dn} = '0;
      ps = 2'b00; sb = 2'b00; op = 2'b00;
      case (s)
         1:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         2:  sb = 2'b11;
         3:  begin sa = 1; sb = 2'b10; end
         4:  begin mrd = 1; io = 1; end
         5:  begin m2r = 1; rw = 1; dn = 1; end
         6:  begin mwr = 1; io = 1; dn = mr; end
         7:  begin sa = 1; op = 2'b10; end
         8:  begin rd = 1; rw = 1; dn = 1; end
         9:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; dn = 1; end
         10: begin sa = 1; sb = 2'b10; end
         11: begin rw = 1; dn = 1; end
         12: begin ps = 2'b10; pcw = 1; dn = 1; end
         default: ;
      endcase
      return {mrd, mwr, io, irw, pcw, br, ps, sa, sb, op, rd, m2r, rw, dn};
   endfunction

   // Reference model: each decoded instruction becomes a script of phases.
   int exp_state = 0;
   bit exp_illegal = 0;
   bit model_valid = 0;
   int script[$];

   always @(posedge clk) begin
      if (reset) begin
         exp_state   = 0;
         exp_illegal = 0;
         script.delete();
         model_valid = 1;
      end else if (model_valid) begin
         if (exp_state == 0) exp_state = 1;
         else if ((exp_state == 1 || exp_state == 4 || exp_state == 6) && !mem_ready) ;
         else if (exp_state == 1) exp_state = 2;
         else if (exp_state == 2) begin
            script.delete();
            case (opcode)
               OP_LW:   script = {3, 4, 5};
               OP_SW:   script = {3, 6};
               OP_R:    script = {7, 8};
               OP_BEQ:  script = {9};
               OP_ADDI: script = {10, 11};
               OP_J:    script = {12};
               default: exp_illegal = 1;
            endcase
            exp_state = (script.size() > 0) ? script.pop_front() : 1;
         end else begin
            exp_state = (script.size() > 0) ? script.pop_front() : 1;
         end
      end
   end

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (model_valid) begin
         check("state", 32'(state), 32'(exp_state));
         check("illegal_op", 32'(illegal_op), 32'(exp_illegal));
         check("outputs", 32'(dut_vec), 32'(exp_out(exp_state, mem_ready)));
      end
   end

   task automatic cyc(input logic r, input logic [5:0] op, input logic mr);
      @(posedge clk);
      #1;
      reset = r; opcode = op; mem_ready = mr;
      @(negedge clk);
   endtask

   initial begin
      int lw_seq[6];
      int n_wr, n_done, lat;
      reset = 1'b1; opcode = OP_R; mem_ready = 1'b0;
      cyc(1, OP_R, 0);
      cyc(1, OP_R, 0);

      // Reset state
      cyc(0, OP_LW, 1);
      check("rst_state", 32'(state), 0);
      check("rst_illegal", 32'(illegal_op), 0);
      check("rst_outputs", 32'(dut_vec), 0);

      // lw with zero wait: 1,2,3,4,5 then back to FETCH
      lw_seq = '{1, 2, 3, 4, 5, 1};
      for (int i = 0; i < 6; i++) begin
         cyc(0, OP_LW, 1);
         check("lw_state", 32'(state), 32'(lw_seq[i]));
         check("lw_done", 32'(instr_done), (lw_seq[i] == 5) ? 1 : 0);
         if (lw_seq[i] == 5) begin
            check("lw_reg_write", 32'(reg_write), 1);
            check("lw_mem_to_reg", 32'(mem_to_reg), 1);
         end
      end

      // R-type
      cyc(0, OP_R, 1); check("r_decode", 32'(state), 2);
      cyc(0, OP_R, 1); check("r_exec", 32'(state), 7);
      check("r_alu_op", 32'(alu_op), 2);
      cyc(0, OP_R, 1); check("r_wb", 32'(state), 8);
      check("r_reg_dst", 32'(reg_dst), 1);
      check("r_reg_write", 32'(reg_write), 1);
      cyc(0, OP_R, 1); check("r_back", 32'(state), 1);

      // sw with three wait cycles in MEMWR
      lat = 1; n_wr = 0; n_done = 0;
      cyc(0, OP_SW, 1); lat++; check("sw_decode", 32'(state), 2);
      cyc(0, OP_SW, 1); lat++; check("sw_memadr", 32'(state), 3);
      for (int i = 0; i < 4; i++) begin
         cyc(0, OP_SW, (i == 3) ? 1'b1 : 1'b0); lat++;
         check("sw_memwr", 32'(state), 6);
         check("sw_done_vs_ready", 32'(instr_done), 32'(mem_ready));
         n_wr += int'(mem_write);
         n_done += int'(instr_done);
      end
      cyc(0, OP_BEQ, 1); check("sw_back", 32'(state), 1);
      check("sw_mem_write_cycles", 32'(n_wr), 4);
      check("sw_done_pulses", 32'(n_done), 1);
      check("sw_latency", 32'(lat), 7);

      // beq then j
      cyc(0, OP_BEQ, 1); check("beq_decode", 32'(state), 2);
      cyc(0, OP_BEQ, 1); check("beq_state", 32'(state), 9);
      check("beq_alu_op", 32'(alu_op), 1);
      check("beq_pc_src", 32'(pc_src), 1);
      check("beq_branch", 32'(branch), 1);
      cyc(0, OP_J, 1); check("beq_back", 32'(state), 1);
      cyc(0, OP_J, 1); check("j_decode", 32'(state), 2);
      cyc(0, OP_J, 1); check("j_state", 32'(state), 12);
      check("j_pc_src", 32'(pc_src), 2);
      check("j_pc_write", 32'(pc_write), 1);

      // FETCH stalled two cycles
      cyc(0, OP_J, 0); check("fstall_state", 32'(state), 1);
      check("fstall_ir_pc", 32'({ir_write, pc_write}), 0);
      cyc(0, OP_J, 0); check("fstall_ir_pc2", 32'({ir_write, pc_write}), 0);
      cyc(0, OP_ILL, 1); check("fready_ir_pc", 32'({ir_write, pc_write}), 3);

      // Illegal opcode, sticky flag, reset mid-MEMRD stall
      cyc(0, OP_ILL, 1); check("ill_decode", 32'(state), 2);
      check("ill_not_yet", 32'(illegal_op), 0);
      check("ill_no_done", 32'(instr_done), 0);
      cyc(0, OP_LW, 1); check("ill_to_fetch", 32'(state), 1);
      check("ill_set", 32'(illegal_op), 1);
      cyc(0, OP_LW, 1); check("ill_lw_decode", 32'(state), 2);
      cyc(0, OP_LW, 1); check("ill_sticky", 32'(illegal_op), 1);
      cyc(0, OP_LW, 0); check("memrd_stall", 32'(state), 4);
      cyc(0, OP_LW, 0); check("memrd_stall2", 32'(state), 4);
      cyc(1, OP_LW, 0); check("memrd_rst_cycle", 32'(state), 4);
      cyc(0, OP_LW, 1); check("midrst_state", 32'(state), 0);
      check("midrst_illegal", 32'(illegal_op), 0);
      check("midrst_outputs", 32'(dut_vec), 0);
      cyc(0, OP_LW, 1); check("midrst_fetch", 32'(state), 1);

      // Randomized traffic; opcode only changes while it is not yet meaningful
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         reset = ($urandom_range(0, 249) == 0);
         mem_ready = ($urandom_range(0, 9) < 6);
         if (exp_state == 0 || exp_state == 1) begin
            case ($urandom_range(0, 7))
               0: opcode = OP_R;
               1: opcode = OP_LW;
               2: opcode = OP_SW;
               3: opcode = OP_BEQ;
               4: opcode = OP_ADDI;
               5: opcode = OP_J;
               default: opcode = 6'($urandom);
            endcase
         end
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
